// File: rtl/pa_fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pa_fpu_pkg
// Description : Shared FPU operand-format, FCLASS bit and field-width constants.
// Revision    : 1.0 - initial release
// ============================================================================
package pa_fpu_pkg;

    typedef enum logic [1:0] {
        FMT_S   = 2'b00,
        FMT_D   = 2'b01,
        FMT_H   = 2'b10,
        FMT_RSV = 2'b11
    } fpu_fmt_e;

    localparam int c_cls_w       = 10;
    localparam int c_cls_neg_inf = 0;
    localparam int c_cls_neg_nrm = 1;
    localparam int c_cls_neg_sub = 2;
    localparam int c_cls_neg_zer = 3;
    localparam int c_cls_pos_zer = 4;
    localparam int c_cls_pos_sub = 5;
    localparam int c_cls_pos_nrm = 6;
    localparam int c_cls_pos_inf = 7;
    localparam int c_cls_snan    = 8;
    localparam int c_cls_qnan    = 9;

    localparam int c_h_exp_w  = 5;
    localparam int c_h_frac_w = 10;
    localparam int c_s_exp_w  = 8;
    localparam int c_s_frac_w = 23;
    localparam int c_d_exp_w  = 11;
    localparam int c_d_frac_w = 52;

endpackage
`default_nettype wire

// File: rtl/pa_fpu_src_class1.sv
`default_nettype none
// ============================================================================
// Module      : pa_fpu_src_class1
// Description : Combinational FCLASS decoder for one operand (H/S/D, NaN-boxing).
// Revision    : 1.0 - initial release
// ============================================================================
module pa_fpu_src_class1
    import pa_fpu_pkg::*;
#(
    parameter int FLEN = 64
) (
    input  logic [1:0]         i_fmt,
    input  logic [FLEN-1:0]    i_src,
    output logic [c_cls_w-1:0] o_class
);

    // Bits above FLEN read as ones, so a 32-bit FPU always sees single as boxed.
    logic [63:0] w_src;
    logic        w_fmt_h;
    logic        w_fmt_d;
    logic        w_sign;
    logic        w_exp_ones;
    logic        w_exp_zero;
    logic        w_frac_zero;
    logic        w_frac_msb;
    logic        w_boxed;

    assign w_src   = ~64'(~i_src);
    assign w_fmt_h = (i_fmt == FMT_H);
    assign w_fmt_d = (i_fmt == FMT_D) && (FLEN == 64);

    always_comb begin
        w_sign      = 1'b0;
        w_exp_ones  = 1'b0;
        w_exp_zero  = 1'b0;
        w_frac_zero = 1'b0;
        w_frac_msb  = 1'b0;
        w_boxed     = 1'b1;
        if (w_fmt_h) begin
            w_sign      = w_src[c_h_exp_w + c_h_frac_w];
            w_exp_ones  = &w_src[c_h_frac_w +: c_h_exp_w];
            w_exp_zero  = ~|w_src[c_h_frac_w +: c_h_exp_w];
            w_frac_zero = ~|w_src[c_h_frac_w-1:0];
            w_frac_msb  = w_src[c_h_frac_w-1];
            w_boxed     = &w_src[63:16];
        end else if (w_fmt_d) begin
            w_sign      = w_src[c_d_exp_w + c_d_frac_w];
            w_exp_ones  = &w_src[c_d_frac_w +: c_d_exp_w];
            w_exp_zero  = ~|w_src[c_d_frac_w +: c_d_exp_w];
            w_frac_zero = ~|w_src[c_d_frac_w-1:0];
            w_frac_msb  = w_src[c_d_frac_w-1];
        end else begin
            w_sign      = w_src[c_s_exp_w + c_s_frac_w];
            w_exp_ones  = &w_src[c_s_frac_w +: c_s_exp_w];
            w_exp_zero  = ~|w_src[c_s_frac_w +: c_s_exp_w];
            w_frac_zero = ~|w_src[c_s_frac_w-1:0];
            w_frac_msb  = w_src[c_s_frac_w-1];
            w_boxed     = &w_src[63:32];
        end
    end

    always_comb begin
        o_class = '0;
        if (!w_boxed) begin
            o_class[c_cls_qnan] = 1'b1;
        end else if (w_exp_ones) begin
            if (w_frac_zero) begin
                if (w_sign) o_class[c_cls_neg_inf] = 1'b1;
                else        o_class[c_cls_pos_inf] = 1'b1;
            end else if (w_frac_msb) begin
                o_class[c_cls_qnan] = 1'b1;
            end else begin
                o_class[c_cls_snan] = 1'b1;
            end
        end else if (w_exp_zero) begin
            if (w_frac_zero) begin
                if (w_sign) o_class[c_cls_neg_zer] = 1'b1;
                else        o_class[c_cls_pos_zer] = 1'b1;
            end else begin
                if (w_sign) o_class[c_cls_neg_sub] = 1'b1;
                else        o_class[c_cls_pos_sub] = 1'b1;
            end
        end else begin
            if (w_sign) o_class[c_cls_neg_nrm] = 1'b1;
            else        o_class[c_cls_pos_nrm] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pa_fpu_src_classify_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pa_fpu_src_classify_pipe
// Description : NUM_SRC operand classifier behind a 2-entry valid/ready skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module pa_fpu_src_classify_pipe
    import pa_fpu_pkg::*;
#(
    parameter int FLEN    = 64,
    parameter int NUM_SRC = 3
) (
    input  logic                       forever_cpuclk,
    input  logic                       cpurst,
    input  logic                       flush,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [1:0]                 in_fmt,
    input  logic [NUM_SRC*FLEN-1:0]    in_src,
    input  logic [3:0]                 in_tag,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [NUM_SRC*c_cls_w-1:0] out_class,
    output logic                       out_any_snan,
    output logic                       out_any_nan,
    output logic                       out_fmt_err,
    output logic [3:0]                 out_tag
);

    localparam int c_pw = NUM_SRC*c_cls_w + 7;

    logic [NUM_SRC*c_cls_w-1:0] w_class;
    logic                       w_any_snan;
    logic                       w_any_nan;
    logic                       w_fmt_err;
    logic [c_pw-1:0]            w_pay;
    logic [c_pw-1:0]            w_head_pay;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_wr_sel;
    logic [1:0]                 w_count_nxt;

    logic [c_pw-1:0]            r_buf0;
    logic [c_pw-1:0]            r_buf1;
    logic                       r_head;
    logic [1:0]                 r_count;
    logic                       r_in_rdy;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        pa_fpu_src_class1 #(
            .FLEN (FLEN)
        ) u_class1 (
            .i_fmt   (in_fmt),
            .i_src   (in_src[k*FLEN +: FLEN]),
            .o_class (w_class[k*c_cls_w +: c_cls_w])
        );
    end

    always_comb begin
        w_any_snan = 1'b0;
        w_any_nan  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_any_snan = w_any_snan | w_class[k*c_cls_w + c_cls_snan];
            w_any_nan  = w_any_nan  | w_class[k*c_cls_w + c_cls_snan]
                                    | w_class[k*c_cls_w + c_cls_qnan];
        end
    end

    assign w_fmt_err = (in_fmt == FMT_RSV) || ((in_fmt == FMT_D) && (FLEN == 32));
    assign w_pay     = {w_class, w_any_snan, w_any_nan, w_fmt_err, in_tag};

    assign w_push = in_vld && r_in_rdy;
    assign w_pop  = (r_count != 2'd0) && out_rdy;
    // Tail slot: the head when empty, the other slot when one entry is held.
    assign w_wr_sel = r_head ^ r_count[0];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
            r_in_rdy <= 1'b1;
        end else if (flush) begin
            r_head   <= 1'b0;
            r_count  <= 2'd0;
            r_in_rdy <= 1'b1;
        end else begin
            if (w_push && !w_wr_sel) r_buf0 <= w_pay;
            if (w_push &&  w_wr_sel) r_buf1 <= w_pay;
            if (w_pop)               r_head <= ~r_head;
            r_count  <= w_count_nxt;
            r_in_rdy <= (w_count_nxt < 2'd2);
        end
    end

    assign w_head_pay = r_head ? r_buf1 : r_buf0;
    assign in_rdy     = r_in_rdy;
    assign out_vld    = (r_count != 2'd0);
    assign {out_class, out_any_snan, out_any_nan, out_fmt_err, out_tag} = w_head_pay;

endmodule
`default_nettype wire
